video_pattern_gen: RTL
======================

// Module: video_pattern_gen
// PURPOSE
//  Parametrised successor to the fixed 1080p color-bar source on the HDMI-out path.
//  Generates HS/VS/DE timing for any raster, plus one of four test patterns selectable at run time.
//  Feeds vout_* (clk = clk_video) directly, or sits ahead of the pixel processing chain as a stimulus source.
// PARAMETERS
//  H_ACTIVE   1920  active pixels per line
//  H_FP       88    horizontal front porch (clocks)
//  H_SYNC     44    HS pulse width (clocks)
//  H_BP       148   horizontal back porch (clocks)
//  V_ACTIVE   1080  active lines per frame
//  V_FP       4     vertical front porch (lines)
//  V_SYNC     5     VS pulse width (lines)
//  V_BP       36    vertical back porch (lines)
//  HS_POL     1     HS asserted level
//  VS_POL     1     VS asserted level
//  DW         8     bits per colour channel
//  CHK_LOG2   5     checkerboard tile edge = 2**CHK_LOG2 pixels
// PORTS
//  clk            in   1     pixel clock; the only clock
//  rst            in   1     reset; asynchronous, active-high
//  mode_i         in   2     0 bars, 1 grey ramp, 2 checker, 3 solid
//  solid_rgb_i    in   3*DW  {r,g,b} for mode 3
//  hs             out  1     horizontal sync, HS_POL polarity
//  vs             out  1     vertical sync, VS_POL polarity
//  de             out  1     data enable
//  rgb_r/g/b      out  DW    pixel channels
//  frame_start_o  out  1     1-cycle pulse coincident with pixel (0,0)
// BEHAVIOUR
//  - H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. hc counts 0..H_TOTAL-1; wraps to 0.
//    vc increments when hc wraps, counts 0..V_TOTAL-1, then wraps to 0.
//  - Line order: active, FP, sync, BP (same for frame). hs active when
//    H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; vs likewise on vc, switching at hc==0.
//  - All outputs registered: counter state in cycle n appears on the outputs in cycle n+1.
//  - de = (hc<H_ACTIVE)&&(vc<V_ACTIVE). rgb = 0 whenever de = 0.
//  - Reset: hc=vc=0, hs=~HS_POL, vs=~VS_POL, de=0, rgb=0, frame_start_o=0, mode_q=0, solid_q=0.
//    First output cycle after release: pixel (0,0), de=1, frame_start_o=1. Reset mid-frame aborts
//    the frame immediately; no partial-line recovery.
//  - mode_i and solid_rgb_i are sampled into mode_q and solid_q only in the last cycle of the
//    frame (hc=H_TOTAL-1, vc=V_TOTAL-1). Mid-frame changes take effect on the next frame, never tear.
//  - Pattern position x = hc (or shifted; see CONFIGURATION), y = vc:
//    mode 0: 8 bars, bar k covers k*H_ACTIVE/8 <= x < (k+1)*H_ACTIVE/8 (integer division);
//      colours in order white,yellow,cyan,green,magenta,red,blue,black; channel on = all-ones.
//    mode 1: r=g=b = floor(x*2**DW/H_ACTIVE). Use an accumulator, not a divider; exact result required.
//    mode 2: all-ones when x[CHK_LOG2]^y[CHK_LOG2], else 0, for all three channels.
//    mode 3: solid_q.
//  - Elaboration must fail (assertion or $error) if any timing parameter is 0 or H_ACTIVE < 8.
// CONFIGURATION
//  PATTERN_SCROLL_EN defined: off register (width clog2(H_ACTIVE)) increments mod H_ACTIVE
//    in the last cycle of each frame; x = (hc+off) mod H_ACTIVE, so modes 0-2 scroll left
//    1 px/frame. off resets to 0. Mode 3 and the timing outputs are unaffected.
//  Not defined: off logic absent, x = hc; output identical to off = 0.
// TESTING  (bench parameters: H 16/2/3/3 -> H_TOTAL 24, V 4/1/2/1 -> V_TOTAL 8, DW 8, CHK_LOG2 1)
//  1 Release rst, run 2 frames -> de high 16 clk/line on 4 lines; hs high clk 19-21 after each line
//    start; vs high lines 5-6; frame_start_o high every 192 clk, aligned with first de.
//  2 mode 0 -> active line reads FFFFFF x2, FFFF00 x2, 00FFFF x2 ... 000000 x2; blanking rgb = 0.
//  3 mode 1 -> grey values 0,16,32,...,240 across x = 0..15.
//  4 mode 2 -> line 0 pattern 00,00,FF,FF repeating; line 2 inverted.
//  5 Switch mode_i 0->3 with solid_rgb_i=123456 mid-frame -> current frame stays bars;
//    next frame all active pixels 123456.
//  6 Assert rst mid-line for 3 clk -> outputs reach the reset values asynchronously; after release
//    the sequence is identical to test 1. With PATTERN_SCROLL_EN: mode 0 frame 1 x=0 = FFFFFF,
//    x=1 = FFFF00.

Source files
------------

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_gen
// Purpose  : Raster timing (HS/VS/DE) for any geometry with bars / grey ramp /
//            checker / solid test patterns. Define PATTERN_SCROLL_EN to scroll
//            modes 0-2 left by one pixel per frame.
// Revision : 1.0  initial release
// ============================================================================
module video_pattern_gen #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   DW       = 8,
  parameter int   CHK_LOG2 = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode_i,
  input  logic [3*DW-1:0] solid_rgb_i,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic [DW-1:0]   rgb_r,
  output logic [DW-1:0]   rgb_g,
  output logic [DW-1:0]   rgb_b,
  output logic            frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int GQ_INC  = (1 << DW) / H_ACTIVE;
  localparam int GR_INC  = (1 << DW) % H_ACTIVE;

  if (H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $error("video_pattern_gen: timing parameter is zero or H_ACTIVE < 8");
  end

  // Quotient/remainder step of floor(x * 2**DW / H_ACTIVE) as x advances by one.
  function automatic logic [DW+XW-1:0] ramp_next(input logic [DW-1:0] q,
                                                 input logic [XW-1:0] r);
    logic [XW:0] s;
    s = {1'b0, r} + (XW+1)'(GR_INC);
    if (s >= (XW+1)'(H_ACTIVE))
      return {q + DW'(GQ_INC + 1), XW'(s - (XW+1)'(H_ACTIVE))};
    return {q + DW'(GQ_INC), s[XW-1:0]};
  endfunction

  logic [HW-1:0]   hc_q, hc_d;
  logic [VW-1:0]   vc_q, vc_d;
  logic [1:0]      mode_q;
  logic [3*DW-1:0] solid_q;
  logic [DW-1:0]   gq_q, gq_d;
  logic [XW-1:0]   gr_q, gr_d;
  logic            line_end_w, frame_end_w;
  logic [XW-1:0]   x_w;
  logic [DW-1:0]   line_gq_w;
  logic [XW-1:0]   line_gr_w;

  assign line_end_w  = (hc_q == HW'(H_TOTAL - 1));
  assign frame_end_w = line_end_w && (vc_q == VW'(V_TOTAL - 1));

  always_comb begin
    hc_d = line_end_w ? '0 : hc_q + 1'b1;
    vc_d = vc_q;
    if (line_end_w) vc_d = frame_end_w ? '0 : vc_q + 1'b1;
  end

`ifdef PATTERN_SCROLL_EN
  logic [XW-1:0] off_q, off_d, offr_q, offr_d;
  logic [DW-1:0] offg_q, offg_d;
  logic [HW:0]   xsum_w;

  // The offset carries its own ramp accumulator so each line can start mid-ramp.
  always_comb begin
    off_d  = off_q;
    offg_d = offg_q;
    offr_d = offr_q;
    if (frame_end_w) begin
      if (off_q == XW'(H_ACTIVE - 1)) begin
        off_d  = '0;
        offg_d = '0;
        offr_d = '0;
      end else begin
        off_d            = off_q + 1'b1;
        {offg_d, offr_d} = ramp_next(offg_q, offr_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q  <= '0;
      offg_q <= '0;
      offr_q <= '0;
    end else begin
      off_q  <= off_d;
      offg_q <= offg_d;
      offr_q <= offr_d;
    end
  end

  assign xsum_w    = {1'b0, hc_q} + (HW+1)'(off_q);
  assign x_w       = (xsum_w >= (HW+1)'(H_ACTIVE)) ? XW'(xsum_w - (HW+1)'(H_ACTIVE))
                                                   : XW'(xsum_w);
  assign line_gq_w = offg_d;
  assign line_gr_w = offr_d;
`else
  assign x_w       = XW'(hc_q);
  assign line_gq_w = '0;
  assign line_gr_w = '0;
`endif

  always_comb begin
    {gq_d, gr_d} = ramp_next(gq_q, gr_q);
    if (x_w == XW'(H_ACTIVE - 1)) begin
      gq_d = '0;
      gr_d = '0;
    end
    if (line_end_w) begin
      gq_d = line_gq_w;
      gr_d = line_gr_w;
    end
  end

  logic            de_w, hs_act_w, vs_act_w, chk_w;
  logic [2:0]      bar_w;
  logic [3*DW-1:0] pix_w;

  always_comb begin
    de_w     = (hc_q < HW'(H_ACTIVE)) && (vc_q < VW'(V_ACTIVE));
    hs_act_w = (hc_q >= HW'(H_ACTIVE + H_FP)) && (hc_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_act_w = (vc_q >= VW'(V_ACTIVE + V_FP)) && (vc_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    chk_w    = |((32'(x_w) ^ 32'(vc_q)) & (32'd1 << CHK_LOG2));
    bar_w    = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (32'(x_w) >= 32'(k * H_ACTIVE / 8)) bar_w = 3'(k);
    end
    // Bar order white..black maps to r=~b1, g=~b2, b=~b0 of the bar index.
    case (mode_q)
      2'd0:    pix_w = {{DW{~bar_w[1]}}, {DW{~bar_w[2]}}, {DW{~bar_w[0]}}};
      2'd1:    pix_w = {3{gq_q}};
      2'd2:    pix_w = {(3*DW){chk_w}};
      default: pix_w = solid_q;
    endcase
    if (!de_w) pix_w = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_q          <= '0;
      vc_q          <= '0;
      mode_q        <= '0;
      solid_q       <= '0;
      gq_q          <= '0;
      gr_q          <= '0;
      hs            <= ~HS_POL;
      vs            <= ~VS_POL;
      de            <= 1'b0;
      rgb_r         <= '0;
      rgb_g         <= '0;
      rgb_b         <= '0;
      frame_start_o <= 1'b0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      gq_q <= gq_d;
      gr_q <= gr_d;
      if (frame_end_w) begin
        mode_q  <= mode_i;
        solid_q <= solid_rgb_i;
      end
      hs                    <= hs_act_w ? HS_POL : ~HS_POL;
      vs                    <= vs_act_w ? VS_POL : ~VS_POL;
      de                    <= de_w;
      {rgb_r, rgb_g, rgb_b} <= pix_w;
      frame_start_o         <= (hc_q == '0) && (vc_q == '0);
    end
  end

endmodule
`default_nettype wire
